// File: rtl/sram_pkg.sv
// Shared definitions for the dual-port handshake SRAM: lane/index width helpers,
// per-port response-state encoding and response error codes.
package sram_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } resp_state_t;

    localparam logic SRAM_ERR_NONE  = 1'b0;
    localparam logic SRAM_ERR_RANGE = 1'b1;

    function automatic int sram_lanes(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int sram_ofs_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int sram_idx_bits(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/sram_port_ctrl.sv
// One request/response port of sram_dp_hs: ready/accept, IDLE/RESP state machine,
// held response registers and (with SRAM_DP_BOUNDS_CHECK_EN) the address range check.
module sram_port_ctrl
    import sram_pkg::*;
#(
    parameter int WORDS      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic [ADDR_WIDTH-1:0]                  i_addr,
    input  logic [DATA_WIDTH/8-1:0]                i_wstrb,
    input  logic                                   i_rready,
    input  logic [DATA_WIDTH-1:0]                  i_mem_word,
    output logic                                   o_rvalid,
    output logic [DATA_WIDTH-1:0]                  o_rdata,
    output logic                                   o_rerr,
    output logic [sram_idx_bits(WORDS)-1:0]        o_idx,
    output logic                                   o_rd_en,
    output logic [DATA_WIDTH/8-1:0]                o_wr_lanes
);

    localparam int NB  = sram_lanes(DATA_WIDTH);
    localparam int OFS = sram_ofs_bits(DATA_WIDTH);
    localparam int IDX = sram_idx_bits(WORDS);

    resp_state_t r_state;
    resp_state_t w_state_next;
    logic        r_rd_sel;
    logic        r_rerr;
    logic        w_accept;
    logic        w_is_read;
    logic        w_oob;
    logic        w_unused_addr;

    // Byte-offset bits (and, without the range check, the high bits) carry no meaning here.
    assign w_unused_addr = ^i_addr;

`ifdef SRAM_DP_BOUNDS_CHECK_EN
    if (OFS + IDX < ADDR_WIDTH) begin : g_range
        assign w_oob = |i_addr[ADDR_WIDTH-1:OFS+IDX];
    end else begin : g_no_range
        assign w_oob = 1'b0;
    end
`else
    assign w_oob = 1'b0;
`endif

    assign o_rvalid   = (r_state == ST_RESP);
    assign o_ready    = !o_rvalid || i_rready;
    assign w_accept   = i_valid && o_ready;
    assign w_is_read  = ~|i_wstrb;
    assign o_idx      = i_addr[OFS+IDX-1:OFS];
    assign o_rd_en    = w_accept && w_is_read && !w_oob;
    assign o_wr_lanes = (w_accept && !w_oob) ? i_wstrb : {NB{1'b0}};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RESP;
            ST_RESP: if (i_rready && !w_accept) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The array output register only loads on an accepted read, so gating it with
    // r_rd_sel yields held read data, and zero for writes, errors and reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_sel <= 1'b0;
            r_rerr   <= SRAM_ERR_NONE;
        end else if (w_accept) begin
            r_rd_sel <= w_is_read && !w_oob;
            r_rerr   <= w_oob ? SRAM_ERR_RANGE : SRAM_ERR_NONE;
        end else if (o_rvalid && i_rready) begin
            r_rd_sel <= 1'b0;
            r_rerr   <= SRAM_ERR_NONE;
        end
    end

    assign o_rdata = r_rd_sel ? i_mem_word : {DATA_WIDTH{1'b0}};
    assign o_rerr  = r_rerr;

endmodule

// File: rtl/sram_dp_hs.sv
// Dual-port synchronous SRAM with valid/ready request and response handshakes per port.
// Optional out-of-range error reporting is enabled by defining SRAM_DP_BOUNDS_CHECK_EN.
module sram_dp_hs
    import sram_pkg::*;
#(
    parameter int WORDS      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ADDR_WIDTH-1:0]     a_addr,
    input  logic [DATA_WIDTH/8-1:0]   a_wstrb,
    input  logic [DATA_WIDTH-1:0]     a_wdata,
    output logic                      a_rvalid,
    input  logic                      a_rready,
    output logic [DATA_WIDTH-1:0]     a_rdata,
    output logic                      a_rerr,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [ADDR_WIDTH-1:0]     b_addr,
    input  logic [DATA_WIDTH/8-1:0]   b_wstrb,
    input  logic [DATA_WIDTH-1:0]     b_wdata,
    output logic                      b_rvalid,
    input  logic                      b_rready,
    output logic [DATA_WIDTH-1:0]     b_rdata,
    output logic                      b_rerr
);

    localparam int NB  = sram_lanes(DATA_WIDTH);
    localparam int IDX = sram_idx_bits(WORDS);

    logic [DATA_WIDTH-1:0] r_mem [WORDS];
    logic [DATA_WIDTH-1:0] r_a_word;
    logic [DATA_WIDTH-1:0] r_b_word;

    logic [IDX-1:0] w_a_idx;
    logic [IDX-1:0] w_b_idx;
    logic           w_a_rd_en;
    logic           w_b_rd_en;
    logic [NB-1:0]  w_a_lanes;
    logic [NB-1:0]  w_b_lanes;
    logic [NB-1:0]  w_b_lanes_eff;
    logic           w_same_idx;

    sram_port_ctrl #(
        .WORDS      (WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port_a (
        .clk        (clk),
        .resetn     (resetn),
        .i_valid    (a_valid),
        .o_ready    (a_ready),
        .i_addr     (a_addr),
        .i_wstrb    (a_wstrb),
        .i_rready   (a_rready),
        .i_mem_word (r_a_word),
        .o_rvalid   (a_rvalid),
        .o_rdata    (a_rdata),
        .o_rerr     (a_rerr),
        .o_idx      (w_a_idx),
        .o_rd_en    (w_a_rd_en),
        .o_wr_lanes (w_a_lanes)
    );

    sram_port_ctrl #(
        .WORDS      (WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port_b (
        .clk        (clk),
        .resetn     (resetn),
        .i_valid    (b_valid),
        .o_ready    (b_ready),
        .i_addr     (b_addr),
        .i_wstrb    (b_wstrb),
        .i_rready   (b_rready),
        .i_mem_word (r_b_word),
        .o_rvalid   (b_rvalid),
        .o_rdata    (b_rdata),
        .o_rerr     (b_rerr),
        .o_idx      (w_b_idx),
        .o_rd_en    (w_b_rd_en),
        .o_wr_lanes (w_b_lanes)
    );

    // On a same-word collision port A owns every lane it strobes; B keeps the rest.
    assign w_same_idx = (w_a_idx == w_b_idx);

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign w_b_lanes_eff[gi] = w_b_lanes[gi] && !(w_a_lanes[gi] && w_same_idx);
    end

    // Non-blocking reads sample the pre-write word, giving read-first on both ports.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_a_lanes[i]) begin
                r_mem[w_a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
            if (w_b_lanes_eff[i]) begin
                r_mem[w_b_idx][i*8 +: 8] <= b_wdata[i*8 +: 8];
            end
        end
        if (w_a_rd_en) begin
            r_a_word <= r_mem[w_a_idx];
        end
        if (w_b_rd_en) begin
            r_b_word <= r_mem[w_b_idx];
        end
    end

endmodule

// File: tb/tb_sram_dp_hs.sv
// Directed, table-driven bench for sram_dp_hs (default build or SRAM_DP_BOUNDS_CHECK_EN).
module tb_sram_dp_hs;

`ifdef SRAM_DP_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_valid, a_ready, a_rvalid, a_rready, a_rerr;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_wstrb;
    logic        b_valid, b_ready, b_rvalid, b_rready, b_rerr;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_wstrb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sram_dp_hs #(
        .WORDS      (256),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_wstrb  (a_wstrb),
        .a_wdata  (a_wdata),
        .a_rvalid (a_rvalid),
        .a_rready (a_rready),
        .a_rdata  (a_rdata),
        .a_rerr   (a_rerr),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_wstrb  (b_wstrb),
        .b_wdata  (b_wdata),
        .b_rvalid (b_rvalid),
        .b_rready (b_rready),
        .b_rdata  (b_rdata),
        .b_rerr   (b_rerr)
    );

    typedef struct {
        logic        a_valid;
        logic [31:0] a_addr;
        logic [3:0]  a_wstrb;
        logic [31:0] a_wdata;
        logic        a_rready;
        logic        b_valid;
        logic [31:0] b_addr;
        logic [3:0]  b_wstrb;
        logic [31:0] b_wdata;
        logic        b_rready;
        logic        xa_ready;
        logic        xb_ready;
        logic        xa_rvalid;
        logic [31:0] xa_rdata;
        logic        xb_rvalid;
        logic [31:0] xb_rdata;
    } vec_t;

    localparam int NV = 11;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [31:0] ad, input logic [3:0] st,
                           input logic [31:0] wd, input logic rr);
        a_valid = v; a_addr = ad; a_wstrb = st; a_wdata = wd; a_rready = rr;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] ad, input logic [3:0] st,
                           input logic [31:0] wd, input logic rr);
        b_valid = v; b_addr = ad; b_wstrb = st; b_wdata = wd; b_rready = rr;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //          a: v   addr    strb  wdata         rr   b: v   addr    strb  wdata         rr   ardy brdy arv  ardata        brv  brdata
        vec[0]  = '{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,  4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0};
        vec[1]  = '{1'b1, 32'h10, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0,  4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vec[2]  = '{1'b1, 32'h20, 4'hF, 32'h11223344, 1'b1, 1'b0, 32'h0,  4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0};
        vec[3]  = '{1'b1, 32'h20, 4'h1, 32'h000000AA, 1'b1, 1'b1, 32'h20, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1, 32'h11223344};
        vec[4]  = '{1'b1, 32'h20, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0,  4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h112233AA, 1'b0, 32'h0};
        vec[5]  = '{1'b1, 32'h30, 4'h3, 32'h000000FF, 1'b1, 1'b1, 32'h30, 4'hF, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1, 32'h0};
        vec[6]  = '{1'b0, 32'h0,  4'h0, 32'h0,        1'b1, 1'b1, 32'h30, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h123400FF};
        vec[7]  = '{1'b0, 32'h0,  4'h0, 32'h0,        1'b1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
        vec[8]  = '{1'b0, 32'h0,  4'h0, 32'h0,        1'b1, 1'b1, 32'h40, 4'hC, 32'h55660000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
        vec[9]  = '{1'b1, 32'h40, 4'h0, 32'h0,        1'b1, 1'b1, 32'h10, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h5566F00D, 1'b1, 32'hDEADBEEF};
        vec[10] = '{1'b0, 32'h0,  4'h0, 32'h0,        1'b1, 1'b0, 32'h0,  4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};

        resetn = 1'b0;
        drive_a(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        drive_b(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset a_rvalid", {31'b0, a_rvalid}, 32'h0);
        chk("reset b_rvalid", {31'b0, b_rvalid}, 32'h0);
        chk("reset a_ready", {31'b0, a_ready}, 32'h1);
        chk("reset b_ready", {31'b0, b_ready}, 32'h1);
        chk("reset a_rdata", a_rdata, 32'h0);
        chk("reset b_rdata", b_rdata, 32'h0);
        chk("reset a_rerr", {31'b0, a_rerr}, 32'h0);
        $display("reset: a_rvalid=%0b b_rvalid=%0b a_ready=%0b b_ready=%0b", a_rvalid, b_rvalid, a_ready, b_ready);
        resetn = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            drive_a(vec[i].a_valid, vec[i].a_addr, vec[i].a_wstrb, vec[i].a_wdata, vec[i].a_rready);
            drive_b(vec[i].b_valid, vec[i].b_addr, vec[i].b_wstrb, vec[i].b_wdata, vec[i].b_rready);
            #1;
            chk($sformatf("v%0d a_ready", i), {31'b0, a_ready}, {31'b0, vec[i].xa_ready});
            chk($sformatf("v%0d b_ready", i), {31'b0, b_ready}, {31'b0, vec[i].xb_ready});
            step();
            chk($sformatf("v%0d a_rvalid", i), {31'b0, a_rvalid}, {31'b0, vec[i].xa_rvalid});
            chk($sformatf("v%0d b_rvalid", i), {31'b0, b_rvalid}, {31'b0, vec[i].xb_rvalid});
            if (vec[i].xa_rvalid) begin
                chk($sformatf("v%0d a_rdata", i), a_rdata, vec[i].xa_rdata);
                chk($sformatf("v%0d a_rerr", i), {31'b0, a_rerr}, 32'h0);
            end
            if (vec[i].xb_rvalid) begin
                chk($sformatf("v%0d b_rdata", i), b_rdata, vec[i].xb_rdata);
                chk($sformatf("v%0d b_rerr", i), {31'b0, b_rerr}, 32'h0);
            end
            $display("vec %0d: a_rvalid=%0b a_rdata=%08h b_rvalid=%0b b_rdata=%08h",
                     i, a_rvalid, a_rdata, b_rvalid, b_rdata);
        end

        // Backpressure: A holds a read beat while B rewrites the same word.
        drive_a(1'b1, 32'h10, 4'h0, 32'h0, 1'b0);
        drive_b(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        step();
        chk("bp first a_rvalid", {31'b0, a_rvalid}, 32'h1);
        chk("bp first a_rdata", a_rdata, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 32'h10, 4'h0, 32'h0, 1'b0);
            drive_b(1'b1, 32'h10, 4'hF, 32'h01020304 + 32'(i), 1'b1);
            #1;
            chk($sformatf("bp%0d a_ready", i), {31'b0, a_ready}, 32'h0);
            step();
            chk($sformatf("bp%0d a_rvalid", i), {31'b0, a_rvalid}, 32'h1);
            chk($sformatf("bp%0d a_rdata", i), a_rdata, 32'hDEADBEEF);
            $display("bp %0d: a_ready=%0b a_rvalid=%0b a_rdata=%08h", i, a_ready, a_rvalid, a_rdata);
        end
        drive_a(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        drive_b(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        #1;
        chk("bp release a_ready", {31'b0, a_ready}, 32'h1);
        step();
        chk("bp drained a_rvalid", {31'b0, a_rvalid}, 32'h0);
        chk("bp drained a_ready", {31'b0, a_ready}, 32'h1);
        drive_a(1'b1, 32'h10, 4'h0, 32'h0, 1'b1);
        step();
        chk("bp reread a_rdata", a_rdata, 32'h01020307);
        $display("bp reread: a_rdata=%08h", a_rdata);

        // Range: 0x400 lies outside 256 words; with the check off it aliases to word 0.
        drive_a(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        drive_b(1'b1, 32'h0, 4'hF, 32'h0BADF00D, 1'b1);
        step();
        drive_b(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        drive_a(1'b1, 32'h400, 4'h0, 32'h0, 1'b1);
        step();
        chk("oob read a_rerr", {31'b0, a_rerr}, BOUNDS ? 32'h1 : 32'h0);
        chk("oob read a_rdata", a_rdata, BOUNDS ? 32'h0 : 32'h0BADF00D);
        $display("oob read: a_rerr=%0b a_rdata=%08h", a_rerr, a_rdata);
        drive_a(1'b1, 32'h400, 4'hF, 32'h77777777, 1'b1);
        step();
        chk("oob write a_rerr", {31'b0, a_rerr}, BOUNDS ? 32'h1 : 32'h0);
        chk("oob write a_rdata", a_rdata, 32'h0);
        drive_a(1'b1, 32'h0, 4'h0, 32'h0, 1'b1);
        step();
        chk("oob after a_rdata", a_rdata, BOUNDS ? 32'h0BADF00D : 32'h77777777);
        chk("oob after a_rerr", {31'b0, a_rerr}, 32'h0);
        $display("oob after: a_rdata=%08h", a_rdata);

        // Reset while a beat is pending drops it immediately.
        drive_a(1'b1, 32'h10, 4'h0, 32'h0, 1'b0);
        step();
        chk("prerst a_rvalid", {31'b0, a_rvalid}, 32'h1);
        drive_a(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        resetn = 1'b0;
        #1;
        chk("midrst a_rvalid", {31'b0, a_rvalid}, 32'h0);
        chk("midrst a_ready", {31'b0, a_ready}, 32'h1);
        chk("midrst a_rdata", a_rdata, 32'h0);
        $display("mid reset: a_rvalid=%0b a_ready=%0b a_rdata=%08h", a_rvalid, a_ready, a_rdata);
        @(negedge clk);
        resetn = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_dp_hs.md
# sram_dp_hs

Parametrised dual-port synchronous SRAM with per-port valid/ready request and response handshakes, byte-lane write strobes and configurable word width and depth. It is the next-generation data memory for the SoC: CPU load/store on port A and a DMA or debug master on port B, replacing the single-port, always-ready data RAM. Writes complete in the array on the request handshake. Every accepted request, read or write, produces exactly one response beat, with optional out-of-range error reporting.

## Interface
- `WORDS`, 256: depth in words; must be a power of two and at least 2.
- `DATA_WIDTH`, 32: word width in bits; must be 32 or 64.
- `ADDR_WIDTH`, 32: width of the byte address.
- Derived values:
  - `NB` = `DATA_WIDTH`/8, the number of byte lanes.
  - `OFS` = log2(`NB`), the number of byte-offset bits.
  - `IDX` = log2(`WORDS`), the number of word-index bits.
- `clk`: input, 1 bit. Single clock; everything is on the rising edge.
- `resetn`: input, 1 bit. Asynchronous, active-low reset.
- Port A requests:
  - `a_valid`: input, 1 bit. Request present.
  - `a_ready`: output, 1 bit. Request accepted when `a_valid` and `a_ready` are both high.
  - `a_addr`: input, `ADDR_WIDTH` bits. Byte address; the low `OFS` bits are ignored (aligned accesses only).
  - `a_wstrb`: input, `NB` bits. Byte write enables; all zeros means a read.
  - `a_wdata`: input, `DATA_WIDTH` bits. Write data.
- Port A responses:
  - `a_rvalid`: output, 1 bit. Response beat present.
  - `a_rready`: input, 1 bit. Response consumed when `a_rvalid` and `a_rready` are both high.
  - `a_rdata`: output, `DATA_WIDTH` bits. Read data; all zeros for write responses.
  - `a_rerr`: output, 1 bit. Address-range error (see Configuration).
- Port B: identical set of ports with the `b_` prefix.

## Operation
- Word index is `addr[OFS+IDX-1:OFS]`.
- Address bits above `OFS+IDX`:
  - With the bounds check compiled in, any nonzero bit there means out of range.
  - Without it, those bits are ignored and the address aliases.
- Ready and response rule, per port:
  - `x_ready = !x_rvalid || x_rready`, so each port holds at most one outstanding response.
  - On an accepted request, `x_rvalid` is set on the next edge.
  - `x_rvalid` is cleared on a response handshake when no new request is accepted in the same cycle.
  - Simultaneous response handshake and new request acceptance gives back-to-back beats: `x_rvalid` stays 1.
- Read: `x_rdata` is the array word as it was *before* any write in the same accept cycle (read-first). This applies to same-port and cross-port writes alike.
- Write: the strobed lanes are updated at the accept edge. The response carries `x_rdata` = 0 and `x_rerr` as defined below.
- Write-write collision: both ports write the same word in the same cycle. Port A's strobed lanes win; port B's lanes that A does not strobe are still written.
- Response stability: while `x_rvalid && !x_rready`, `x_rdata` and `x_rerr` are held unchanged. They are not re-read from the array, even if the other port writes that word.
- Out-of-range request (bounds check compiled in):
  - The array is not touched.
  - The response has `x_rdata` = 0 and `x_rerr` = 1.
- Per-port state: a 2-state machine, IDLE (`rvalid`=0) and RESP (`rvalid`=1).
  - IDLE to RESP on accept.
  - RESP to IDLE on response handshake with no accept.
  - RESP stays in RESP on response handshake with a new accept.
- The array has no reset; its contents are undefined until written.

## Timing
- Request-to-response latency is exactly 1 cycle: accept at edge N gives `rvalid` high after edge N.
- Throughput is 1 request per cycle per port when `rready` is held high.
- Outputs in reset:
  - `a_rvalid` and `b_rvalid` = 0.
  - `a_rdata`, `b_rdata` = 0.
  - `a_rerr`, `b_rerr` = 0.
  - `a_ready` and `b_ready` = 1, because `rvalid` = 0.
- Reset asserted mid-operation: pending responses are dropped and all writes not yet at an edge are lost.
- Combinational paths: `x_ready` depends combinationally on `x_rready`. There is no combinational path from any `addr`, `wdata` or `wstrb` to any output.

## Configuration
- `SRAM_DP_BOUNDS_CHECK_EN`:
  - Defined: out-of-range detection and the `x_rerr` behaviour described above.
  - Undefined: the upper address bits are ignored (aliasing) and `x_rerr` is tied to 0.
- The ports are present in both builds.

## Structure
- Shared package `sram_pkg` holds:
  - byte-lane and index width helper functions (clog2-based);
  - the per-port response-state encoding (IDLE/RESP);
  - `SRAM_ERR_NONE` and `SRAM_ERR_RANGE` constants.
- Sub-module `sram_port_ctrl`, instantiated twice, owns:
  - the accept/ready logic;
  - the response state machine;
  - the held `rdata`/`rerr` registers;
  - the range check.
- The top level owns the array and the collision merge.

## Test plan
- Reset: hold `resetn`=0 for 3 cycles. Expect `a_rvalid`=`b_rvalid`=0, `a_ready`=`b_ready`=1, `rdata`=0.
- Streaming: port A writes 0xDEADBEEF to 0x10 with `wstrb`=0xF, then reads 0x10 with `rready`=1.
  - Two consecutive `rvalid` beats.
  - Second beat `rdata`=0xDEADBEEF.
- Byte strobes and read-first:
  - Write 0x11223344 to 0x20.
  - In one cycle, port A writes 0xAA at `wstrb`=0x1 while port B reads 0x20.
  - Port B gets 0x11223344; a later read returns 0x112233AA.
- Collision: both ports write 0x30 in one cycle, A 0x000000FF with `wstrb`=0x3, B 0x12345678 with `wstrb`=0xF. A later read gives 0x123400FF.
- Backpressure:
  - Port A reads 0x10 with `a_rready`=0 for 4 cycles while port B writes 0x10.
  - `a_ready`=0 and `a_rdata` stays at the old value throughout.
  - After `a_rready`=1, the beat completes and `a_ready` returns to 1.
- Bounds (built with `SRAM_DP_BOUNDS_CHECK_EN`, `WORDS`=256, 32-bit): read 0x400. Expect `rerr`=1, `rdata`=0, and no array change.
